// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes, EA mux encodings, op classes and sequencer states for the LC-3 memory sequencer
package lc3_pkg;
    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_JSR = 4'h4;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_STI = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_LEA = 4'hE;

    typedef enum logic [2:0] {
        EA_NONE     = 3'b000,
        EA_PC_OFF9  = 3'b010,
        EA_PC_OFF11 = 3'b011,
        EA_RS1_ZERO = 3'b100,
        EA_RS1_OFF6 = 3'b101
    } ea_ctl_e;

    typedef enum logic [2:0] {CL_NONE, CL_LEA, CL_BR, CL_JUMP, CL_LOAD, CL_STORE, CL_IND} op_class_e;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_MEM1, S_MEM2, S_FIN} state_e;
endpackage

// File: rtl/lc3_mem_sequencer_if.sv
// lc3_mem_sequencer_if: request/acknowledge memory port between the sequencer and memory
interface lc3_mem_sequencer_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master(output req, we, addr, wdata, input rdata, ack);
    modport slave(input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/lc3_ea_decode.sv
// lc3_ea_decode: maps IR[15:11] to the EA mux select and the sequencing class of the instruction
module lc3_ea_decode
    import lc3_pkg::*;
(
    input  logic [4:0] ir_hi,
    output ea_ctl_e    ea_ctl,
    output op_class_e  op_class
);
    // ir_hi[1] is IR[12], which separates loads from stores in every memory opcode pair
    always_comb begin
        ea_ctl   = EA_NONE;
        op_class = CL_NONE;
        case (ir_hi[4:1])
            OP_LD, OP_ST: begin
                ea_ctl   = EA_PC_OFF9;
                op_class = ir_hi[1] ? CL_STORE : CL_LOAD;
            end
            OP_LDR, OP_STR: begin
                ea_ctl   = EA_RS1_OFF6;
                op_class = ir_hi[1] ? CL_STORE : CL_LOAD;
            end
            OP_LDI, OP_STI: begin
                ea_ctl   = EA_PC_OFF9;
                op_class = CL_IND;
            end
            OP_LEA: begin
                ea_ctl   = EA_PC_OFF9;
                op_class = CL_LEA;
            end
            OP_BR: begin
                ea_ctl   = EA_PC_OFF9;
                op_class = CL_BR;
            end
            OP_JSR: begin
                ea_ctl   = ir_hi[0] ? EA_PC_OFF11 : EA_RS1_ZERO;
                op_class = CL_JUMP;
            end
            OP_JMP: begin
                ea_ctl   = EA_RS1_ZERO;
                op_class = CL_JUMP;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lc3_mem_sequencer.sv
// lc3_mem_sequencer: sequences EA selection, up to two memory accesses or a PC redirect per instruction
module lc3_mem_sequencer
    import lc3_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [15:0]                 ir,
    input  logic [2:0]                  nzp,
    input  logic [15:0]                 ea,
    output logic [2:0]                  ea_control,
    input  logic [15:0]                 st_data,
    lc3_mem_sequencer_if.master         mem,
    output logic                        busy,
    output logic                        done,
    output logic                        reg_we,
    output logic [15:0]                 result,
    output logic                        pc_load,
    output logic [15:0]                 pc_target,
    output logic                        link
);
    state_e      state, state_n;
    logic [15:9] ir_r;
    logic [15:0] addr_r, wdata_r;
    ea_ctl_e     dec_ctl;
    op_class_e   op_class;

    lc3_ea_decode u_decode (.ir_hi(ir_r[15:11]), .ea_ctl(dec_ctl), .op_class(op_class));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: state_n = start ? S_CALC : S_IDLE;
            S_CALC: state_n = (op_class inside {CL_LOAD, CL_STORE, CL_IND}) ? S_MEM1 : S_FIN;
            S_MEM1: state_n = !mem.ack ? S_MEM1 : (op_class == CL_IND) ? S_MEM2 : S_FIN;
            S_MEM2: state_n = mem.ack ? S_FIN : S_MEM2;
            default: state_n = S_IDLE;
        endcase
    end

    // Result strobes are armed on entry to FIN and cleared when leaving it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ir_r      <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            result    <= '0;
            pc_target <= '0;
            reg_we    <= 1'b0;
            pc_load   <= 1'b0;
            link      <= 1'b0;
        end else begin
            if (state == S_IDLE && start) ir_r <= ir[15:9];
            if (state == S_FIN) begin
                reg_we  <= 1'b0;
                pc_load <= 1'b0;
                link    <= 1'b0;
            end
            if (state == S_CALC) begin
                addr_r  <= ea;
                wdata_r <= st_data;
                if (op_class == CL_LEA) begin
                    result <= ea;
                    reg_we <= 1'b1;
                end
                if (op_class == CL_JUMP || (op_class == CL_BR && |(ir_r[11:9] & nzp))) begin
                    pc_target <= ea;
                    pc_load   <= 1'b1;
                    link      <= ir_r[15:12] == OP_JSR;
                end
            end
            if (state == S_MEM1 && mem.ack && op_class == CL_IND) addr_r <= mem.rdata;
            if (mem.ack && ((state == S_MEM1 && op_class == CL_LOAD) || (state == S_MEM2 && !ir_r[12]))) begin
                result <= mem.rdata;
                reg_we <= 1'b1;
            end
        end

    assign ea_control = (state == S_CALC) ? dec_ctl : EA_NONE;
    assign busy       = state != S_IDLE;
    assign done       = state == S_FIN;
    assign mem.req    = state == S_MEM1 || state == S_MEM2;
    assign mem.we     = (state == S_MEM1 && op_class == CL_STORE) || (state == S_MEM2 && ir_r[12]);
    assign mem.addr   = addr_r;
    assign mem.wdata  = wdata_r;
endmodule
